// File: rtl/serial_rx_ctrl.sv
// Purpose: serial frame receiver; start detect, mid-bit sampling, MSB-first word assembly, stop check.
// Latency: word is valid the cycle after the stop-bit sample (2-cycle synchronizer on the line input).
// Backpressure: o_valid/i_ready handshake; a good frame arriving while a word is unconsumed is dropped and flagged on o_overrun.
module serial_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 i_arst_n,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   shift_en, shift_clr;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q;

  // Two-flop synchronizer; resets to the idle-high line level so release never looks like a start bit.
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Shift datapath: new bit enters the LSB so the first received bit ends up in the MSB.
  always_comb begin
    shift_d = shift_q;
    if (shift_clr) begin
      shift_d = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[DATA_BITS-2:0], rx_s_q};
    end
  end

  // Next-state, counters, sample strobes and output updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    // Consumer handshake; a word loading in the same cycle overrides this below.
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d   = ST_START;
          cnt_d     = '0;
          shift_clr = 1'b1;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        // Re-check the start bit half a bit in; a high line here was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        // One full bit period after the mid-start sample lands mid-bit of each data bit.
        if (cnt_q == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          idx_d    = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s_q) begin
            if (!valid_q || i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl with DATA_BITS=4, CLKS_PER_BIT=4.
// A frame-level model predicts outputs from closed-form frame timing; every cycle is compared.
// Literal expectations pin the model at key points of the directed sequence.
module tb_serial_rx_ctrl;

  localparam int DB  = 4;
  localparam int CPB = 4;
  // Edge offsets from the first clock edge that samples the start bit on i_rx:
  // 2 sync flops, half-bit start check, DB data bits, one stop bit.
  localparam int FRAME_DONE = 2 + CPB / 2 + CPB * DB + CPB;
  localparam int FALSE_DONE = 2 + CPB / 2;
  localparam int BUSY_FROM  = 2;

  logic          clk = 1'b0;
  logic          i_arst_n = 1'b0;
  logic          i_rx = 1'b1;
  logic          i_ready = 1'b0;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_busy;

  serial_rx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .i_arst_n    (i_arst_n),
    .i_rx        (i_rx),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Frame requests from the stimulus side.
  int            req_cnt = 0;
  int            req_p = 0;
  logic          req_false = 1'b0;
  logic [DB-1:0] req_data = '0;
  logic          req_stop = 1'b1;

  // Model state.
  int            cyc = 0;
  int            ack_cnt = 0;
  logic          fr_active = 1'b0;
  int            fr_p = 0;
  logic          fr_false = 1'b0;
  logic [DB-1:0] fr_data = '0;
  logic          fr_stop = 1'b1;
  logic          exp_valid = 1'b0;
  logic [DB-1:0] exp_data = '0;
  logic          exp_ferr = 1'b0;
  logic          exp_ovr = 1'b0;
  logic          exp_busy = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;

  // Model: expected outputs after each rising edge.
  initial begin
    logic v0;
    int   done;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      if (!i_arst_n) begin
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_busy  = 1'b0;
        fr_active = 1'b0;
        ack_cnt   = req_cnt;
      end else begin
        if (ack_cnt != req_cnt) begin
          ack_cnt   = req_cnt;
          fr_active = 1'b1;
          fr_p      = req_p;
          fr_false  = req_false;
          fr_data   = req_data;
          fr_stop   = req_stop;
        end
        v0 = exp_valid;
        if (exp_valid && i_ready) exp_valid = 1'b0;
        done = fr_p + (fr_false ? FALSE_DONE : FRAME_DONE);
        if (fr_active && cyc == done) begin
          fr_active = 1'b0;
          if (!fr_false) begin
            if (!fr_stop) begin
              exp_ferr = 1'b1;
              // The low stop bit is still in the synchronizer when IDLE returns,
              // so it is seen as a start that the half-bit check then rejects.
              fr_active = 1'b1;
              fr_false  = 1'b1;
              fr_p      = fr_p + CPB * (DB + 2) - 1;
            end else if (!v0 || i_ready) begin
              exp_valid = 1'b1;
              exp_data  = fr_data;
            end else begin
              exp_ovr = 1'b1;
            end
          end
        end
        done = fr_p + (fr_false ? FALSE_DONE : FRAME_DONE);
        exp_busy = fr_active && (cyc >= fr_p + BUSY_FROM) && (cyc < done);
      end
    end
  end

  // One clock: compare at the falling edge, then return just after the next rising edge.
  task automatic tick();
    logic          wv, wf, wo, wb;
    logic [DB-1:0] wd;
    @(negedge clk);
    if (cyc > 0) begin
      wv = i_arst_n ? exp_valid : 1'b0;
      wd = i_arst_n ? exp_data  : '0;
      wf = i_arst_n ? exp_ferr  : 1'b0;
      wo = i_arst_n ? exp_ovr   : 1'b0;
      wb = i_arst_n ? exp_busy  : 1'b0;
      n_tests++;
      if (o_valid !== wv || o_data !== wd || o_frame_err !== wf || o_overrun !== wo || o_busy !== wb) begin
        n_fail++;
        $display("FAIL cycle%0d: got valid=%b data=%b ferr=%b ovr=%b busy=%b, want valid=%b data=%b ferr=%b ovr=%b busy=%b",
                 cyc, o_valid, o_data, o_frame_err, o_overrun, o_busy, wv, wd, wf, wo, wb);
      end
      if (o_frame_err === 1'b1) ferr_seen++;
      if (o_overrun === 1'b1) ovr_seen++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic request(input logic is_false, input logic [DB-1:0] d, input logic stop);
    req_p     = cyc + 1;
    req_false = is_false;
    req_data  = d;
    req_stop  = stop;
    req_cnt   = req_cnt + 1;
  endtask

  // Drives a frame MSB-first; returns just after the edge that samples the last stop-bit cycle.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    request(1'b0, d, stop);
    i_rx = 1'b0;
    idle(CPB);
    for (int b = DB - 1; b >= 0; b--) begin
      i_rx = d[b];
      idle(CPB);
    end
    i_rx = stop;
    idle(CPB);
    i_rx = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 4 && o_valid !== 1'b1; k++) tick();
    check(name, 32'(o_valid), 32'd1);
  endtask

  initial begin
    // Reset with a toggling line.
    i_arst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_rx = i[0];
      tick();
    end
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_busy",  32'(o_busy),  32'd0);
    check("reset_data",  32'(o_data),  32'h0);
    i_rx = 1'b1;
    i_arst_n = 1'b1;
    idle(20);
    check("idle_busy",  32'(o_busy),  32'd0);
    check("idle_valid", 32'(o_valid), 32'd0);

    // Good frame, consumer not ready.
    send_frame(4'b1011, 1'b1);
    wait_valid("frame1_valid");
    check("frame1_data", 32'(o_data), 32'hB);
    idle(4);
    check("frame1_no_ferr", 32'(ferr_seen), 32'd0);

    // Second frame while the first is unconsumed.
    send_frame(4'b0110, 1'b1);
    idle(4);
    check("overrun_once", 32'(ovr_seen), 32'd1);
    check("overrun_data_kept", 32'(o_data), 32'hB);
    check("overrun_valid_kept", 32'(o_valid), 32'd1);

    // One-cycle accept.
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("accept_clears_valid", 32'(o_valid), 32'd0);
    idle(3);

    // Frame error.
    send_frame(4'b0101, 1'b0);
    idle(8);
    check("ferr_once", 32'(ferr_seen), 32'd1);
    check("ferr_valid_kept", 32'(o_valid), 32'd0);
    check("ferr_data_kept", 32'(o_data), 32'hB);
    check("ferr_no_overrun", 32'(ovr_seen), 32'd1);

    // One-clock glitch on the line.
    request(1'b1, '0, 1'b1);
    i_rx = 1'b0;
    tick();
    i_rx = 1'b1;
    idle(2);
    check("glitch_busy_rises", 32'(o_busy), 32'd1);
    idle(CPB / 2 + 3);
    check("glitch_busy_falls", 32'(o_busy), 32'd0);
    check("glitch_no_valid", 32'(o_valid), 32'd0);
    check("glitch_no_ferr", 32'(ferr_seen), 32'd1);

    // Reset during the third data bit.
    request(1'b0, 4'b1001, 1'b1);
    i_rx = 1'b0;
    idle(CPB);
    i_rx = 1'b1;
    idle(CPB);
    i_rx = 1'b0;
    idle(CPB);
    i_rx = 1'b0;
    idle(2);
    i_arst_n = 1'b0;
    i_rx = 1'b1;
    idle(2);
    i_arst_n = 1'b1;
    idle(30);
    check("midreset_no_valid", 32'(o_valid), 32'd0);
    check("midreset_idle", 32'(o_busy), 32'd0);

    // Clean frame after the mid-frame reset.
    send_frame(4'b1001, 1'b1);
    wait_valid("frame_after_reset_valid");
    check("frame_after_reset_data", 32'(o_data), 32'h9);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("final_accept", 32'(o_valid), 32'd0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Frame-level receive controller for the serial-in/parallel-out shift path. It watches a raw asynchronous serial line, detects start bits, and times mid-bit sampling with a clock-divider counter. It enables the shift datapath once per data bit, checks the stop bit, and hands the assembled word to the consumer over a valid/ready handshake. It sits between the serial pin and any word-level consumer (FIFO, command decoder).

Parameters:
DATA_BITS, 8, data bits per frame (>=2); also o_data width.
CLKS_PER_BIT, 16, clk cycles per serial bit period (even, >=4).

Ports:
clk  input  1  system clock, all state on rising edge.
i_arst_n  input  1  reset, asynchronous, active-low.
i_rx  input  1  raw serial line, asynchronous, idle high.
i_ready  input  1  consumer accepts o_data when high with o_valid.
o_data  output  DATA_BITS  received word, MSB-first (first data bit ends in bit DATA_BITS-1).
o_valid  output  1  o_data holds an unconsumed word.
o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
o_overrun  output  1  one-cycle pulse: good frame dropped because o_valid was still high.
o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, while i_arst_n=0): state IDLE; sync flops 1; shift reg 0; bit/clock counters 0; o_data 0; o_valid 0; o_frame_err 0; o_overrun 0; o_busy 0.
- i_rx passes through a 2-flop synchronizer (rx_s) before any use. Add 2 cycles of input latency.
- Shift datapath: internal DATA_BITS register. When shift_en=1, it loads {reg[DATA_BITS-2:0], rx_s} (new bit enters the LSB, shifts toward the MSB). It holds otherwise. It is cleared on entry to START.
- Clock counter: cnt, width clog2(CLKS_PER_BIT). Bit counter: idx, width clog2(DATA_BITS+1).
- IDLE: if rx_s==0, go to START with cnt=0 and shift reg cleared.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with cnt=0 and idx=0. If 1 (glitch/false start), return to IDLE with no output.
- DATA:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT-1: assert shift_en for that single cycle, set cnt=0, increment idx.
  - When the sample with idx==DATA_BITS-1 is taken, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s, then go to IDLE.
  - rx_s==1 and (o_valid==0 or i_ready==1): load o_data from the shift reg; o_valid=1 from the next cycle.
  - rx_s==1, o_valid==1, i_ready==0: o_data unchanged; pulse o_overrun for 1 cycle.
  - rx_s==0: pulse o_frame_err for 1 cycle; o_data and o_valid unchanged.
- Handshake:
  - o_valid clears the cycle after o_valid&&i_ready, unless a new word loads in that same cycle (load wins; o_valid stays 1).
  - o_data is stable while o_valid=1.
- No new start is recognized until IDLE is re-entered. A line held low after a frame error begins a new START immediately after returning to IDLE.
- i_arst_n asserted mid-frame: immediate return to reset values. The partial word is discarded and nothing is emitted after release.
- o_busy is a registered decode of state!=IDLE.

Test Plan:
(Bench uses DATA_BITS=4, CLKS_PER_BIT=4; one bit = 4 clk.)
- Reset: hold i_arst_n=0 with i_rx toggling -> o_valid=0, o_busy=0, o_data=4'b0000. Release with i_rx=1 -> still idle after 20 cycles.
- Good frame: drive start 0, bits 1,0,1,1, stop 1 (4 clk each), i_ready=0 -> o_valid rises within 3 cycles of the stop sample; o_data=4'b1011; o_frame_err=0.
- Handshake and overrun:
  - Keep i_ready=0 and send a second frame 0110 -> o_overrun pulses once; o_data stays 4'b1011.
  - Raise i_ready for 1 cycle -> o_valid falls the next cycle.
- Frame error: send data 0101 with stop bit 0 -> o_frame_err high exactly 1 cycle; o_valid unchanged; o_data unchanged.
- False start: pulse i_rx low for 1 clk only -> o_busy rises, then returns to 0 within CLKS_PER_BIT/2+3 cycles; no o_valid, no error.
- Reset mid-frame: assert i_arst_n=0 during data bit 2 for 2 cycles, then idle line -> no o_valid. A subsequent clean frame 1001 yields o_data=4'b1001.
